// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch timekeeper.
package stopwatch_pkg;

  localparam int unsigned TIME_WIDTH = 6;
  localparam int unsigned STATE_WIDTH = 2;

  localparam logic [TIME_WIDTH-1:0] MAX_SECONDS = TIME_WIDTH'(59);
  localparam logic [TIME_WIDTH-1:0] MAX_MINUTES = TIME_WIDTH'(59);

  // State enumeration
  localparam logic [STATE_WIDTH-1:0] ST_IDLE    = 2'd0;
  localparam logic [STATE_WIDTH-1:0] ST_RUNNING = 2'd1;
  localparam logic [STATE_WIDTH-1:0] ST_PAUSED  = 2'd2;

  typedef struct packed {
    logic [TIME_WIDTH-1:0] minutes;
    logic [TIME_WIDTH-1:0] seconds;
  } mmss_t;

  // Advance mm:ss by one second, wrapping 59:59 to 00:00
  function automatic mmss_t mmss_inc(input mmss_t t);
    mmss_t r;
    r = t;
    if (t.seconds >= MAX_SECONDS) begin
      r.seconds = '0;
      if (t.minutes >= MAX_MINUTES) begin
        r.minutes = '0;
      end else begin
        r.minutes = t.minutes + TIME_WIDTH'(1);
      end
    end else begin
      r.seconds = t.seconds + TIME_WIDTH'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/button_edge.sv
// Two-flop synchronizer plus registered rising-edge detector for one button.
// A level held high across reset produces no pulse until it has been seen low.
module button_edge (
  input  logic clock,
  input  logic reset,
  input  logic i_button,
  output logic o_pulse
);

  logic       r_sync1;
  logic       r_sync2;
  logic       r_sync3;
  logic [1:0] r_vld;
  logic       r_armed;
  logic       r_pulse;

  // Synchronize, arm on a genuine low level, then emit one pulse per rising edge
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
      r_vld   <= 2'b00;
      r_armed <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_sync1 <= i_button;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      r_vld   <= {r_vld[0], 1'b1};
      if (r_vld[1] && !r_sync2) begin
        r_armed <= 1'b1;
      end
      r_pulse <= r_armed & r_sync2 & ~r_sync3;
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/stopwatch_timekeeper.sv
// Stopwatch: IDLE/RUNNING/PAUSED control, seconds prescaler, mm:ss count and lap freeze.
module stopwatch_timekeeper
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICK_DIVISOR = 100000000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start_stop,
  input  logic                  clear,
  input  logic                  lap,
  output logic [TIME_WIDTH-1:0] minutes,
  output logic [TIME_WIDTH-1:0] seconds,
  output logic                  running,
  output logic                  lap_active,
  output logic                  rollover
);

  localparam int unsigned PRESC_W = (TICK_DIVISOR > 2) ? $clog2(TICK_DIVISOR) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIVISOR - 1);

  logic                   w_start_p;
  logic                   w_clear_p;
  logic                   w_lap_p;
  logic [STATE_WIDTH-1:0] r_state;
  logic [STATE_WIDTH-1:0] w_state_nxt;
  logic [PRESC_W-1:0]     r_presc;
  logic                   w_tick;
  logic                   w_at_max;
  logic                   w_lap_toggle;
  mmss_t                  r_time;
  mmss_t                  w_time_inc;
  mmss_t                  r_disp;
  logic                   r_running;
  logic                   r_lap_active;
  logic                   r_rollover;

  button_edge u_start_edge (
    .clock    (clock),
    .reset    (reset),
    .i_button (start_stop),
    .o_pulse  (w_start_p)
  );

  button_edge u_clear_edge (
    .clock    (clock),
    .reset    (reset),
    .i_button (clear),
    .o_pulse  (w_clear_p)
  );

  button_edge u_lap_edge (
    .clock    (clock),
    .reset    (reset),
    .i_button (lap),
    .o_pulse  (w_lap_p)
  );

  assign w_tick       = (r_state == ST_RUNNING) && (r_presc == PRESC_LAST);
  assign w_at_max     = (r_time.minutes == MAX_MINUTES) && (r_time.seconds == MAX_SECONDS);
  assign w_time_inc   = mmss_inc(r_time);
  assign w_lap_toggle = w_lap_p && !w_clear_p && (r_state != ST_IDLE);

  // Next-state logic; clear dominates start_stop
  always_comb begin
    w_state_nxt = r_state;
    if (w_clear_p) begin
      w_state_nxt = ST_IDLE;
    end else if (w_start_p) begin
      case (r_state)
        ST_IDLE:    w_state_nxt = ST_RUNNING;
        ST_RUNNING: w_state_nxt = ST_PAUSED;
        ST_PAUSED:  w_state_nxt = ST_RUNNING;
        default:    w_state_nxt = ST_IDLE;
      endcase
    end else if (r_state != ST_IDLE && r_state != ST_RUNNING && r_state != ST_PAUSED) begin
      w_state_nxt = ST_IDLE;
    end
  end

  // State register and registered status flags
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_running    <= 1'b0;
      r_lap_active <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_running <= (w_state_nxt == ST_RUNNING);
      if (w_clear_p) begin
        r_lap_active <= 1'b0;
      end else if (w_lap_toggle) begin
        r_lap_active <= ~r_lap_active;
      end
    end
  end

  // Prescaler advances only while running and holds its phase while paused
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_presc <= '0;
    end else if (w_clear_p) begin
      r_presc <= '0;
    end else if (r_state == ST_RUNNING) begin
      r_presc <= w_tick ? '0 : r_presc + PRESC_W'(1);
    end
  end

  // Internal mm:ss count and rollover pulse
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_time     <= '0;
      r_rollover <= 1'b0;
    end else if (w_clear_p) begin
      r_time     <= '0;
      r_rollover <= 1'b0;
    end else begin
      r_rollover <= w_tick && w_at_max;
      if (w_tick) begin
        r_time <= w_time_inc;
      end
    end
  end

  // Display follows the internal count one cycle late, frozen while lap is active
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_disp <= '0;
    end else if (w_clear_p) begin
      r_disp <= '0;
    end else if (!r_lap_active) begin
      r_disp <= r_time;
    end
  end

  assign minutes    = r_disp.minutes;
  assign seconds    = r_disp.seconds;
  assign running    = r_running;
  assign lap_active = r_lap_active;
  assign rollover   = r_rollover;

endmodule
